// File: rtl/manch_uart_rx.sv
// Manchester-coded UART receiver: 2-flop sync, chip sampling, valid/ready out.
// Define MANCH_RX_RESYNC_EN to re-centre sampling on every mid-bit transition.
module manch_uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int BAUDRATE  = 115200,
  parameter int CLK_FREQ  = 18_750_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 err_manch,
  output logic                 err_frame,
  output logic                 err_overrun
);

  localparam int FULLBAUD = CLK_FREQ / BAUDRATE;
  localparam int HALFBAUD = FULLBAUD / 2;
  localparam int QUARTER  = FULLBAUD / 4;
  localparam int CW       = $clog2(FULLBAUD);
  localparam int BW       = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(FULLBAUD - 1);
  localparam logic [CW-1:0] CNT_A    = CW'(QUARTER);
  localparam logic [CW-1:0] CNT_B    = CW'(HALFBAUD + QUARTER);
  localparam logic [CW-1:0] CNT_MID  = CW'(HALFBAUD);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    START = 3'b001,
    DATA  = 3'b010,
    STOP  = 3'b100
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 chip_a_q, chip_a_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;

  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 manch_q, manch_d;
  logic                 frame_q, frame_d;
  logic                 ovr_q, ovr_d;

  logic                 fall;
  logic                 resync;
  logic                 done;
  logic                 cnt_wrap;
  logic [CW-1:0]        cnt_step;

  assign fall     = rx_prev_q & ~rx_s_q;
  assign cnt_wrap = (cnt_q == CNT_LAST);

`ifdef MANCH_RX_RESYNC_EN
  localparam int EIGHTH = FULLBAUD / 8;
  localparam logic [CW-1:0] WIN_LO = CW'(HALFBAUD - EIGHTH);
  localparam logic [CW-1:0] WIN_HI = CW'(HALFBAUD + EIGHTH);
  localparam logic [CW-1:0] CNT_RS = CW'(HALFBAUD + 1);

  logic rx_edge;
  logic in_win;

  assign rx_edge = rx_prev_q ^ rx_s_q;
  assign in_win  = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
  assign resync  = rx_edge && in_win;
  assign cnt_step = resync ? CNT_RS
                  : cnt_wrap ? '0 : cnt_q + CW'(1);
`else
  assign resync   = 1'b0;
  assign cnt_step = cnt_wrap ? '0 : cnt_q + CW'(1);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      chip_a_q   <= 1'b0;
      shift_q    <= '0;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      manch_q    <= 1'b0;
      frame_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      chip_a_q   <= chip_a_d;
      shift_q    <= shift_d;
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      rx_prev_q  <= rx_s_q;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      manch_q    <= manch_d;
      frame_q    <= frame_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    chip_a_d = chip_a_q;
    shift_d  = shift_q;
    manch_d  = 1'b0;
    frame_d  = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        // the detect cycle itself is count 0
        if (fall) begin
          state_d = START;
          cnt_d   = CW'(1);
        end
      end
      START: begin
        cnt_d = cnt_step;
        if (cnt_q == CNT_A) begin
          chip_a_d = rx_s_q;
          if (rx_s_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (cnt_q == CNT_B && !rx_s_q) begin
          frame_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_wrap) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        cnt_d = cnt_step;
        if (cnt_q == CNT_A) begin
          chip_a_d = rx_s_q;
        end else if (cnt_q == CNT_B) begin
          if (chip_a_q == rx_s_q) begin
            manch_d = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
            bit_d   = '0;
          end else begin
            shift_d[bit_q] = chip_a_q;
          end
        end else if (cnt_wrap) begin
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      STOP: begin
        cnt_d = cnt_step;
        if (cnt_q == CNT_MID) begin
          if (!rx_s_q) begin
            frame_d = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
            bit_d   = '0;
          end else if (bit_q == STP_LAST) begin
            // leave early so a start edge in the tail half is caught
            done    = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
            bit_d   = '0;
          end
        end else if (cnt_wrap) begin
          bit_d = bit_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    ovr_d      = 1'b0;
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign err_manch   = manch_q;
  assign err_frame   = frame_q;
  assign err_overrun = ovr_q;

endmodule

// File: tb/tb_manch_uart_rx.sv
// Bench for manch_uart_rx: random Manchester frames scored by a chip-level
// frame decoder, plus overrun, glitch, mid-frame reset and drift cases.
`timescale 1ns/1ps
module tb_manch_uart_rx;

  localparam int FB = 18_750_000 / 115200;
  localparam int HB = FB / 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       err_manch;
  logic       err_frame;
  logic       err_overrun;

  int n_vec = 0;
  int n_bad = 0;

  int         n_word = 0;
  int         n_manch = 0;
  int         n_frame = 0;
  int         n_ovr = 0;
  int         v_hi = 0;
  logic [7:0] last_word = '0;
  logic       v_prev = 1'b0;

  manch_uart_rx dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .err_manch   (err_manch),
    .err_frame   (err_frame),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  // event monitor: words are counted on each rising rx_valid
  always @(negedge clk) begin
    if (!reset_n) begin
      v_prev = 1'b0;
    end else begin
      if (rx_valid && !v_prev) begin
        n_word++;
        last_word = rx_data;
      end
      if (rx_valid) v_hi++;
      if (err_manch) n_manch++;
      if (err_frame) n_frame++;
      if (err_overrun) n_ovr++;
      v_prev = rx_valid;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // chip list for a frame; kind 0 good, 1 bit p sent d,d, 2 stop low,
  // 3 start sent 0,0. Frames that break are cut at the broken symbol.
  function automatic void build(input logic [7:0] d, input int kind,
                                input int p, output logic [39:0] c,
                                output int n);
    c = '1;
    c[0] = 1'b0;
    c[1] = (kind != 3);
    n = 2;
    if (kind == 3) return;
    for (int i = 0; i < 8; i++) begin
      c[2+2*i] = d[i];
      c[3+2*i] = (kind == 1 && i == p) ? d[i] : ~d[i];
      if (kind == 1 && i == p) begin
        n = 4 + 2 * i;
        return;
      end
    end
    c[18] = (kind != 2);
    c[19] = (kind != 2);
    n = 20;
  endfunction

  // 0 nothing, 1 word, 2 manchester error, 3 framing error
  function automatic void decode(input logic [39:0] c, input int n,
                                 output int res, output logic [7:0] w);
    w = '0;
    res = 0;
    if (n < 2 || c[0]) return;
    if (!c[1]) begin
      res = 3;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      if (3 + 2 * i >= n) return;
      if (c[2+2*i] == c[3+2*i]) begin
        res = 2;
        return;
      end
      w[i] = c[2+2*i];
    end
    if (n < 20) return;
    res = c[18] ? 1 : 3;
  endfunction

  task automatic tx_chips(input logic [39:0] c, input int n,
                          input int half, input int tail);
    for (int i = 0; i < n; i++) begin
      rx = c[i];
      repeat (half) @(negedge clk);
    end
    rx = 1'b1;
    repeat (tail) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input logic [39:0] c,
                           input int n);
    int         w0, m0, f0, o0, res;
    logic [7:0] w;
    w0 = n_word;
    m0 = n_manch;
    f0 = n_frame;
    o0 = n_ovr;
    decode(c, n, res, w);
    tx_chips(c, n, HB, 3 * FB);
    chk({tag, " words"}, n_word - w0, (res == 1));
    chk({tag, " err_manch"}, n_manch - m0, (res == 2));
    chk({tag, " err_frame"}, n_frame - f0, (res == 3));
    chk({tag, " err_overrun"}, n_ovr - o0, 0);
    if (res == 1) chk({tag, " data"}, last_word, w);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, " rx_data"}, rx_data, 0);
    chk({tag, " rx_valid"}, rx_valid, 0);
    chk({tag, " err_manch"}, err_manch, 0);
    chk({tag, " err_frame"}, err_frame, 0);
    chk({tag, " err_overrun"}, err_overrun, 0);
  endtask

  initial begin
    logic [39:0] c;
    int          n, w0, m0, f0, o0, h0, g;
    logic [7:0]  d;

    #2 reset_n = 1'b0;
    #20;
    chk_cleared("reset");
    @(negedge clk) reset_n = 1'b1;
    repeat (20) @(negedge clk);

    // basic 0xA5, one-cycle valid pulse with rx_ready high
    h0 = v_hi;
    build(8'hA5, 0, 0, c, n);
    run_frame("basic", c, n);
    chk("basic valid width", v_hi - h0, 1);

    // back-to-back with consumer stalled: second word overruns
    rx_ready = 1'b0;
    w0 = n_word;
    m0 = n_manch;
    f0 = n_frame;
    o0 = n_ovr;
    build(8'h00, 0, 0, c, n);
    tx_chips(c, 19, HB, HB + 41);
    build(8'hFF, 0, 0, c, n);
    tx_chips(c, n, HB, 3 * FB);
    chk("b2b words", n_word - w0, 1);
    chk("b2b err_overrun", n_ovr - o0, 1);
    chk("b2b err_other", (n_manch - m0) + (n_frame - f0), 0);
    chk("b2b rx_data", rx_data, 8'h00);
    chk("b2b rx_valid held", rx_valid, 1);
    @(negedge clk) rx_ready = 1'b1;
    @(negedge clk);
    chk("b2b rx_valid drop", rx_valid, 0);

    // short idle glitch shorter than a quarter bit: silent false start
    w0 = n_word;
    m0 = n_manch;
    f0 = n_frame;
    g = $urandom_range(5, 30);
    rx = 1'b0;
    repeat (g) @(negedge clk);
    rx = 1'b1;
    repeat (3 * FB) @(negedge clk);
    chk("glitch words", n_word - w0, 0);
    chk("glitch errors", (n_manch - m0) + (n_frame - f0), 0);

    // directed manchester violation then the clean frame
    build(8'h3C, 1, 2, c, n);
    run_frame("manch 3C", c, n);
    build(8'h3C, 0, 0, c, n);
    run_frame("after manch", c, n);
    build(8'h55, 2, 0, c, n);
    run_frame("stop low", c, n);

    for (int k = 0; k < 14; k++) begin
      build(8'($urandom_range(0, 255)), $urandom_range(0, 3),
            $urandom_range(0, 7), c, n);
      run_frame($sformatf("rand%0d", k), c, n);
    end

    // reset during data bit 4 with a word still pending
    rx_ready = 1'b0;
    d = 8'($urandom_range(0, 255)) | 8'h01;
    build(d, 0, 0, c, n);
    tx_chips(c, n, HB, 3 * FB);
    chk("pend rx_valid", rx_valid, 1);
    chk("pend rx_data", rx_data, d);
    build(8'h81, 0, 0, c, n);
    fork
      tx_chips(c, n, HB, 3 * FB);
      begin
        repeat (11 * HB) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk_cleared("midreset");
      end
    join
    @(negedge clk) reset_n = 1'b1;
    rx_ready = 1'b1;
    repeat (10) @(negedge clk);
    run_frame("post reset", c, n);

    // transmitter running slow by 8 clocks per bit
    w0 = n_word;
    m0 = n_manch;
    build(8'h96, 0, 0, c, n);
    tx_chips(c, n, HB + 4, 20 * FB);
`ifdef MANCH_RX_RESYNC_EN
    chk("resync words", n_word - w0, 1);
    chk("resync data", last_word, 8'h96);
    chk("resync err_manch", n_manch - m0, 0);
`else
    chk("drift noticed",
        (n_manch != m0) || (n_word == w0) || (last_word != 8'h96), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
